rx_frame_buffer: RTL and testbench

Parametrised receive-side frame buffer that sits after the firewall stage of the Ethernet RX chain. It replaces the fixed 32-bit aggregator.
- Packs firewall dibits into WORD_W-bit words and writes them speculatively into a DEPTH-word FIFO.
- Commits or rolls back each frame on the checksum verdict, so downstream sees only whole, good frames, with a last-word marker.
- Keeps saturating good/dropped frame counters for the LED/seven-segment display.

---
 rtl/rx_frame_buffer_pkg.sv | 21 ++
 rtl/rx_dibit_packer.sv | 76 +++++++
 rtl/rx_frame_buffer.sv | 179 +++++++++++++++++
 tb/tb_rx_frame_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the RX frame buffer: dibit width, the frame FSM
// state type and the pointer-width helper used by the FIFO pointers.
// -----------------------------------------------------------------------------
package rx_pkg;

    localparam int DIBIT_W = 2;

    typedef enum logic [1:0] {
        IDLE,   // waiting for the first dibit of a frame
        RECV,   // storing words speculatively
        OVF     // frame no longer fits; consume dibits until done
    } rx_state_t;

    // One extra bit beyond the address lets full and empty be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_dibit_packer.sv
// -----------------------------------------------------------------------------
// rx_dibit_packer
// Shifts MSB-first dibits into WORD_W-bit words.
//   clk, rstn         clock, asynchronous active-low reset
//   dibit_valid_i     dibit_i carries a new dibit this cycle
//   dibit_i           input dibit
//   clear_i           end of frame: drop any partial word and restart
//   word_valid_o      word_o is a completed word (combinational strobe)
//   word_o            completed word, including this cycle's dibit
//   partial_valid_o   a partial word is waiting
//   partial_word_o    partial word, left-justified, low bits zero
// -----------------------------------------------------------------------------
module rx_dibit_packer
    import rx_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               dibit_valid_i,
    input  logic [DIBIT_W-1:0] dibit_i,
    input  logic               clear_i,
    output logic               word_valid_o,
    output logic [WORD_W-1:0]  word_o,
    output logic               partial_valid_o,
    output logic [WORD_W-1:0]  partial_word_o
);

    localparam int DIBITS = WORD_W / DIBIT_W;
    localparam int CNT_W  = $clog2(DIBITS) + 1;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shifted;

    assign shifted = {shift_q[WORD_W-DIBIT_W-1:0], dibit_i};
    assign word_o  = shifted;

    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (dibit_valid_i) begin
            shift_d = shifted;
            if (cnt_q == CNT_W'(DIBITS - 1)) begin
                cnt_d        = '0;
                word_valid_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Shifting left by the missing bit count moves the cnt_q freshest dibits
    // to the top and pushes stale bits of the previous word out.
    assign partial_valid_o = (cnt_q != '0);
    assign partial_word_o  = shift_q << (WORD_W - DIBIT_W * int'(cnt_q));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// rx_frame_buffer
// Packs firewall dibits into words, stores each frame speculatively and
// commits or rolls it back on the checksum verdict, so the reader sees only
// whole good frames.
//   clk, rstn                 clock, asynchronous active-low reset
//   axiiv, axiid              input dibit stream
//   done, kill                end-of-frame pulse and checksum-fail flag
//   axiov, axiod, axiol       committed word, valid and last-word marker
//   axioready                 downstream accepts the word
//   level                     committed words held
//   overflow                  pulse when a frame first overflows
//   frames_ok/frames_dropped  saturating frame statistics
// -----------------------------------------------------------------------------
module rx_frame_buffer
    import rx_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   axiiv,
    input  logic [DIBIT_W-1:0]     axiid,
    input  logic                   done,
    input  logic                   kill,
    output logic                   axiov,
    output logic [WORD_W-1:0]      axiod,
    output logic                   axiol,
    input  logic                   axioready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       frames_ok,
    output logic [CNT_W-1:0]       frames_dropped
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    rx_state_t         state_q, state_d;
    logic [PW-1:0]     rd_q, commit_q, wr_q, wr_d;
    logic              commit_pend_q, commit_pend_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  frames_ok_q, frames_dropped_q;
    logic              ok_inc, drop_inc;

    logic              word_valid, partial_valid;
    logic [WORD_W-1:0] word, partial_word;

    logic              mem_we, last_fix;
    logic [WORD_W:0]   mem_wdata;
    logic [AW-1:0]     fix_addr;
    logic [WORD_W:0]   mem [DEPTH];
    logic [WORD_W:0]   rd_entry;
    logic              full;
    logic              pop;

    rx_dibit_packer #(.WORD_W(WORD_W)) u_packer (
        .clk             (clk),
        .rstn            (rstn),
        .dibit_valid_i   (axiiv),
        .dibit_i         (axiid),
        .clear_i         (done),
        .word_valid_o    (word_valid),
        .word_o          (word),
        .partial_valid_o (partial_valid),
        .partial_word_o  (partial_word)
    );

    // Occupancy is measured against rd_q, so speculative words can never
    // overwrite a word the reader has not taken yet.
    assign full     = ((wr_q - rd_q) == PW'(DEPTH));
    assign fix_addr = wr_q[AW-1:0] - AW'(1);

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        last_fix      = 1'b0;
        commit_pend_d = 1'b0;
        overflow_d    = 1'b0;
        ok_inc        = 1'b0;
        drop_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done while idle is a zero-dibit frame and is ignored.
                if (axiiv && !done) state_d = RECV;
            end
            RECV: begin
                if (done) begin
                    state_d = IDLE;
                    // done together with a dibit is a protocol error: kill.
                    if (kill || axiiv) begin
                        wr_d     = commit_q;
                        drop_inc = 1'b1;
                    end else if (partial_valid) begin
                        if (full) begin
                            wr_d       = commit_q;
                            drop_inc   = 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            mem_we        = 1'b1;
                            mem_wdata     = {1'b1, partial_word};
                            wr_d          = wr_q + 1'b1;
                            commit_pend_d = 1'b1;
                            ok_inc        = 1'b1;
                        end
                    end else begin
                        // Frame ended on a word boundary: mark the last full word.
                        last_fix      = 1'b1;
                        commit_pend_d = 1'b1;
                        ok_inc        = 1'b1;
                    end
                end else if (word_valid) begin
                    if (full) begin
                        state_d    = OVF;
                        overflow_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wdata = {1'b0, word};
                        wr_d      = wr_q + 1'b1;
                    end
                end
            end
            OVF: begin
                if (done) begin
                    state_d  = IDLE;
                    wr_d     = commit_q;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = axiov && axioready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            rd_q             <= '0;
            commit_q         <= '0;
            wr_q             <= '0;
            commit_pend_q    <= 1'b0;
            overflow_q       <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            commit_pend_q <= commit_pend_d;
            overflow_q    <= overflow_d;
            // wr_q already holds the frame's final pointer one cycle after done.
            if (commit_pend_q) commit_q <= wr_q;
            if (pop) rd_q <= rd_q + 1'b1;
            if (ok_inc && frames_ok_q != '1) frames_ok_q <= frames_ok_q + 1'b1;
            if (drop_inc && frames_dropped_q != '1) frames_dropped_q <= frames_dropped_q + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only the pointers do, and an
    // entry is never presented until a commit has written it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_q[AW-1:0]] <= mem_wdata;
        if (last_fix) mem[fix_addr][WORD_W] <= 1'b1;
    end

    assign rd_entry       = mem[rd_q[AW-1:0]];
    assign axiov          = (rd_q != commit_q);
    assign axiod          = axiov ? rd_entry[WORD_W-1:0] : '0;
    assign axiol          = axiov && rd_entry[WORD_W];
    assign level          = commit_q - rd_q;
    assign overflow       = overflow_q;
    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_buffer
// Directed and random frames against a word-level model of the buffer: each
// frame becomes ceil(n/16) left-justified words, accepted only if it is good
// and fits the free space; a queue holds the committed words in order.
// A second instance with 2-bit counters checks counter saturation.
// -----------------------------------------------------------------------------
module tb_rx_frame_buffer;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int DPW    = WORD_W / 2;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   axiiv;
    logic [1:0]             axiid;
    logic                   done;
    logic                   kill;
    logic                   axioready;
    logic                   axiov, axiol, overflow;
    logic [WORD_W-1:0]      axiod;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       frames_ok, frames_dropped;

    logic                   s_axiov, s_axiol, s_overflow;
    logic [WORD_W-1:0]      s_axiod;
    logic [$clog2(DEPTH):0] s_level;
    logic [1:0]             s_frames_ok, s_frames_dropped;

    rx_frame_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .axiiv(axiiv), .axiid(axiid), .done(done), .kill(kill),
        .axiov(axiov), .axiod(axiod), .axiol(axiol), .axioready(axioready),
        .level(level), .overflow(overflow),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    rx_frame_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .axiiv(axiiv), .axiid(axiid), .done(done), .kill(kill),
        .axiov(s_axiov), .axiod(s_axiod), .axiol(s_axiol), .axioready(axioready),
        .level(s_level), .overflow(s_overflow),
        .frames_ok(s_frames_ok), .frames_dropped(s_frames_dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ok_cnt = 0, drop_cnt = 0;
    int ovf_seen = 0, ovf_exp = 0;
    logic [WORD_W:0] exp_q[$];
    logic [WORD_W:0] pend_q[$];

    always @(negedge clk) if (overflow) ovf_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_level"}, level, exp_q.size());
        check({tag, "_axiov"}, axiov, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check({tag, "_axiod"}, axiod, exp_q[0][WORD_W-1:0]);
            check({tag, "_axiol"}, axiol, exp_q[0][WORD_W]);
        end
        check({tag, "_ok"}, frames_ok, ok_cnt);
        check({tag, "_dropped"}, frames_dropped, drop_cnt);
        check({tag, "_sat_ok"}, s_frames_ok, sat3(ok_cnt));
        check({tag, "_sat_dropped"}, s_frames_dropped, sat3(drop_cnt));
        check({tag, "_ovf_pulses"}, ovf_seen, ovf_exp);
    endtask

    // Sends n dibits (counting pattern or random), then done/kill. axioready
    // is held low by the caller, so free space is fixed during the frame.
    task automatic send_frame(input int n, input bit k, input bit seq, input bit gaps);
        logic [1:0]        dib[$];
        logic [1:0]        d;
        logic [WORD_W-1:0] w;
        int free, nfull, nwords, idx;
        for (int i = 0; i < n; i++) begin
            d = seq ? 2'(i % 4) : 2'($urandom_range(0, 3));
            dib.push_back(d);
            if (gaps && $urandom_range(0, 3) == 0) begin
                axiiv = 1'b0;
                tick();
            end
            axiiv = 1'b1;
            axiid = d;
            tick();
        end
        axiiv = 1'b0;
        done  = 1'b1;
        kill  = k;
        tick();
        done = 1'b0;
        kill = 1'b0;
        free   = DEPTH - exp_q.size();
        nfull  = n / DPW;
        nwords = (n + DPW - 1) / DPW;
        if (nfull > free || (!k && nwords > free)) ovf_exp++;
        if (k || nwords > free) begin
            drop_cnt++;
        end else begin
            ok_cnt++;
            for (int wi = 0; wi < nwords; wi++) begin
                w = '0;
                for (int j = 0; j < DPW; j++) begin
                    idx = wi * DPW + j;
                    w = {w[WORD_W-3:0], (idx < n) ? dib[idx] : 2'b00};
                end
                pend_q.push_back({1'(wi == nwords - 1), w});
            end
        end
        // One cycle after done the new frame must not be visible yet.
        check("pre_commit_level", level, exp_q.size());
        check("pre_commit_axiov", axiov, exp_q.size() > 0);
    endtask

    // The commit edge, optionally popping on that same edge.
    task automatic commit_tick(input bit rdy, input string tag);
        axioready = rdy;
        tick();
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        axioready = 1'b0;
        check_state(tag);
    endtask

    // mode 0: random ready, 1: ready high, 2: ready low
    task automatic drain(input int cycles, input int mode);
        bit rdy;
        for (int c = 0; c < cycles; c++) begin
            rdy = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            axioready = rdy;
            check("drain_axiov", axiov, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("drain_axiod", axiod, exp_q[0][WORD_W-1:0]);
                check("drain_axiol", axiol, exp_q[0][WORD_W]);
            end
            tick();
            if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        axioready = 1'b0;
        check("drain_level", level, exp_q.size());
    endtask

    initial begin
        logic [WORD_W:0] first;
        int ovf_before;
        rstn = 1'b0; axiiv = 1'b0; axiid = 2'b00; done = 1'b0; kill = 1'b0; axioready = 1'b0;
        #12;
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_axiol", axiol, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ok", frames_ok, 0);
        check("rst_dropped", frames_dropped, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single good word.
        send_frame(16, 1'b0, 1'b1, 1'b0);
        commit_tick(1'b0, "t1");
        check("t1_word", axiod, 32'h1B1B1B1B);
        check("t1_last", axiol, 1);
        check("t1_level1", level, 1);
        drain(2, 1);
        check("t1_level0", level, 0);

        // Same frame, killed.
        send_frame(16, 1'b1, 1'b1, 1'b0);
        commit_tick(1'b0, "t2");
        check("t2_axiov", axiov, 0);
        check("t2_dropped", frames_dropped, 1);

        // Two words with a left-justified partial tail.
        send_frame(20, 1'b0, 1'b1, 1'b0);
        commit_tick(1'b0, "t3");
        check("t3_word0", axiod, 32'h1B1B1B1B);
        check("t3_last0", axiol, 0);
        axioready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        axioready = 1'b0;
        check("t3_word1", axiod, 32'h1B000000);
        check("t3_last1", axiol, 1);
        drain(2, 1);

        // done while idle changes nothing.
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_state("idle_done");

        // Overflow with one committed word held.
        send_frame(16, 1'b0, 1'b0, 1'b0);
        commit_tick(1'b0, "t4a");
        ovf_before = ovf_seen;
        send_frame(64, 1'b0, 1'b0, 1'b1);
        commit_tick(1'b0, "t4b");
        check("t4_one_pulse", ovf_seen - ovf_before, 1);
        check("t4_level", level, 1);

        // Stability under back-pressure, then pop on the commit edge.
        send_frame(16, 1'b0, 1'b0, 1'b0);
        commit_tick(1'b0, "t5a");
        first = exp_q[0];
        drain(10, 2);
        check("t5_stable", axiod, first[WORD_W-1:0]);
        send_frame(16, 1'b0, 1'b0, 1'b0);
        commit_tick(1'b1, "t5b");
        check("t5_level", level, 2);
        drain(6, 1);

        // Random frames, random back-pressure between frames.
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 80), $urandom_range(0, 3) == 0, 1'b0, 1'b1);
            commit_tick(1'($urandom_range(0, 1)), "rnd");
            drain($urandom_range(0, 8), 0);
        end

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 7; i++) begin
            axiiv = 1'b1;
            axiid = 2'($urandom_range(0, 3));
            tick();
        end
        axiiv = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("t6_axiov", axiov, 0);
        check("t6_axiod", axiod, 0);
        check("t6_axiol", axiol, 0);
        check("t6_level", level, 0);
        check("t6_overflow", overflow, 0);
        check("t6_ok", frames_ok, 0);
        check("t6_dropped", frames_dropped, 0);
        exp_q.delete();
        pend_q.delete();
        ok_cnt = 0;
        drop_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        send_frame(16, 1'b0, 1'b0, 1'b0);
        commit_tick(1'b0, "t6");
        check("t6_one_word", level, 1);
        drain(3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
